// File: rtl/hazard_fwd_unit.sv
// Load-use stall, IF/ID flush and per-operand forwarding selects from a shadow pipeline of destination metadata.
// Latency: stall/flush/selects are combinational (zero cycles); the shadow pipeline and counters update on each clk edge.
// Backpressure: stall holds PC and IF/ID and injects a bubble into stage 1; later stages always advance.
module hazard_fwd_unit #(
  parameter int REG_AW     = 5,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_read_rs,
  input  logic              id_read_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwr,
  input  logic              id_load,
  input  logic              redirect,
  output logic              stall,
  output logic              flush_ifid,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Shadow entry k mirrors the instruction k stages past decode.
  logic [FWD_DEPTH:1]             e_v;
  logic [FWD_DEPTH:1]             e_wr;
  logic [FWD_DEPTH:1]             e_ld;
  logic [FWD_DEPTH:1][REG_AW-1:0] e_dst;

  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             hz_a;
  logic             hz_b;

  // Scan oldest to youngest so the youngest eligible producer overwrites the select last.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    hz_a  = 1'b0;
    hz_b  = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (e_v[k] && e_wr[k] && (e_dst[k] == id_rs) && (id_rs != '0)) begin
        if (!e_ld[k] || (k >= LOAD_STAGE)) sel_a = SEL_W'(k);
        if (e_ld[k] && (k < LOAD_STAGE))   hz_a  = 1'b1;
      end
      if (e_v[k] && e_wr[k] && (e_dst[k] == id_rt) && (id_rt != '0)) begin
        if (!e_ld[k] || (k >= LOAD_STAGE)) sel_b = SEL_W'(k);
        if (e_ld[k] && (k < LOAD_STAGE))   hz_b  = 1'b1;
      end
    end
  end

  // A stall defers the redirect: the branch operands are not ready, decode re-presents it.
  always_comb begin
    stall      = id_valid & ((id_read_rs & hz_a) | (id_read_rt & hz_b));
    flush_ifid = redirect & ~stall;
    fwd_sel_a  = id_valid ? sel_a : '0;
    fwd_sel_b  = id_valid ? sel_b : '0;
  end

  // Shadow pipeline: bubble into stage 1 on stall or empty decode, older stages always shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_v   <= '0;
      e_wr  <= '0;
      e_ld  <= '0;
      e_dst <= '0;
    end else begin
      if (id_valid && !stall) begin
        e_v[1]   <= 1'b1;
        e_dst[1] <= id_dst;
        e_wr[1]  <= id_regwr;
        e_ld[1]  <= id_load;
      end else begin
        e_v[1]   <= 1'b0;
        e_dst[1] <= '0;
        e_wr[1]  <= 1'b0;
        e_ld[1]  <= 1'b0;
      end
      for (int k = 2; k <= FWD_DEPTH; k++) begin
        e_v[k]   <= e_v[k-1];
        e_dst[k] <= e_dst[k-1];
        e_wr[k]  <= e_wr[k-1];
        e_ld[k]  <= e_ld[k-1];
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))      stall_cnt <= stall_cnt + 1'b1;
      if (flush_ifid && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
